// File: rtl/pc_select_ctrl_pkg.sv
// pc_select_ctrl_pkg: shared definitions for the next-PC select block.
//   - PCSEL_* : 2-bit PC-mux select codes driven on 'choose'
//   - pcsel_state_e : controller state encoding
//   - RESET_PC_DEFAULT : default PC loaded on reset
package pc_select_ctrl_pkg;

    localparam int unsigned PCSEL_PC_W = 32;

    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_BR  = 2'b01;
    localparam logic [1:0] PCSEL_J   = 2'b10;
    localparam logic [1:0] PCSEL_JR  = 2'b11;

    localparam logic [PCSEL_PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_3000;

    // StSlot is only reachable when DELAY_SLOT_EN is defined: a redirect has been
    // accepted but the delay-slot sequential fetch has not fired yet.
    typedef enum logic [1:0] {
        StBoot = 2'b00,
        StRun  = 2'b01,
        StHold = 2'b10,
        StSlot = 2'b11
    } pcsel_state_e;

endpackage

// File: rtl/pc_redirect_arb.sv
// pc_redirect_arb: combinational priority encoder for redirect requests.
// Priority jr > jump > br_taken.
// Ports:
//   br_taken/br_target     conditional branch request and target
//   jump/jump_target       j/jal request and target
//   jr/jr_target           jr/jalr request and target
//   valid                  any redirect requested
//   code                   PC-mux code of the winner (PCSEL_SEQ when none)
//   target                 target of the winner (zero when none)
module pc_redirect_arb
    import pc_select_ctrl_pkg::*;
#(
    parameter int unsigned PC_W = 32
) (
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    input  logic            jr,
    input  logic [PC_W-1:0] jr_target,
    output logic            valid,
    output logic [1:0]      code,
    output logic [PC_W-1:0] target
);

    always_comb begin
        valid  = 1'b0;
        code   = PCSEL_SEQ;
        target = '0;
        if (jr) begin
            valid  = 1'b1;
            code   = PCSEL_JR;
            target = jr_target;
        end else if (jump) begin
            valid  = 1'b1;
            code   = PCSEL_J;
            target = jump_target;
        end else if (br_taken) begin
            valid  = 1'b1;
            code   = PCSEL_BR;
            target = br_target;
        end
    end

endmodule

// File: rtl/pc_select_ctrl.sv
// pc_select_ctrl: owns the fetch PC and drives the PC-mux select.
// Arbitrates branch/jump/jr redirects against sequential fetch and buffers a
// redirect that cannot be applied yet so it is never lost.
// Optional feature macro: DELAY_SLOT_EN (one delay-slot fetch at pc+4 before
// the redirect takes effect; redirects arriving while one is buffered are ignored).
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   stall                      pipeline stall; no fetch issued
//   br_taken/br_target         branch redirect request
//   jump/jump_target           jump redirect request
//   jr/jr_target               register-jump redirect request
//   imem_ready                 imem accepts a request this cycle
//   imem_req                   fetch request at pc
//   pc                         registered fetch PC
//   pc_plus4                   pc + 4, wraps
//   choose                     PC-mux select (00 seq, 01 br, 10 j, 11 jr)
//   redirect_pend              a redirect is buffered
module pc_select_ctrl
    import pc_select_ctrl_pkg::*;
#(
    parameter int unsigned      PC_W     = PCSEL_PC_W,
    parameter logic [PC_W-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    input  logic            jr,
    input  logic [PC_W-1:0] jr_target,
    input  logic            imem_ready,
    output logic            imem_req,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4,
    output logic [1:0]      choose,
    output logic            redirect_pend
);

    pcsel_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [1:0]      pend_code_q, pend_code_d;
    logic [PC_W-1:0] pend_target_q, pend_target_d;

    logic            arb_valid;
    logic [1:0]      arb_code;
    logic [PC_W-1:0] arb_target;
    logic            fire;

    pc_redirect_arb #(
        .PC_W (PC_W)
    ) u_arb (
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jump        (jump),
        .jump_target (jump_target),
        .jr          (jr),
        .jr_target   (jr_target),
        .valid       (arb_valid),
        .code        (arb_code),
        .target      (arb_target)
    );

    assign imem_req      = (state_q != StBoot) && !stall;
    assign fire          = imem_req && imem_ready;
    assign pc            = pc_q;
    assign pc_plus4      = pc_q + PC_W'(4);
    assign redirect_pend = (state_q == StHold) || (state_q == StSlot);

`ifndef DELAY_SLOT_EN
    // In HOLD a newer redirect replaces the buffered one.
    logic [1:0]      hold_code;
    logic [PC_W-1:0] hold_target;
    assign hold_code   = arb_valid ? arb_code   : pend_code_q;
    assign hold_target = arb_valid ? arb_target : pend_target_q;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_code_d   = pend_code_q;
        pend_target_d = pend_target_q;
        choose        = PCSEL_SEQ;
        unique case (state_q)
            StBoot: state_d = StRun;
            StRun: begin
                if (arb_valid) begin
`ifdef DELAY_SLOT_EN
                    // Slot fetch goes out sequentially; target applied afterwards.
                    pend_code_d   = arb_code;
                    pend_target_d = arb_target;
                    if (fire) begin
                        pc_d    = pc_plus4;
                        state_d = StHold;
                    end else begin
                        state_d = StSlot;
                    end
`else
                    choose = arb_code;
                    if (fire) begin
                        pc_d = arb_target;
                    end else begin
                        pend_code_d   = arb_code;
                        pend_target_d = arb_target;
                        state_d       = StHold;
                    end
`endif
                end else if (fire) begin
                    pc_d = pc_plus4;
                end
            end
            StHold: begin
`ifdef DELAY_SLOT_EN
                choose = pend_code_q;
                if (fire) begin
                    pc_d    = pend_target_q;
                    state_d = StRun;
                end
`else
                choose = hold_code;
                if (fire) begin
                    pc_d    = hold_target;
                    state_d = StRun;
                end else begin
                    pend_code_d   = hold_code;
                    pend_target_d = hold_target;
                end
`endif
            end
            StSlot: begin
                if (fire) begin
                    pc_d    = pc_plus4;
                    state_d = StHold;
                end
            end
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StBoot;
            pc_q          <= RESET_PC;
            pend_code_q   <= PCSEL_SEQ;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_code_q   <= pend_code_d;
            pend_target_q <= pend_target_d;
        end
    end

endmodule

// File: tb/tb_pc_select_ctrl.sv
module tb_pc_select_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        jr;
    logic [31:0] jr_target;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [1:0]  choose;
    logic        redirect_pend;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];

    pc_select_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .jr            (jr),
        .jr_target     (jr_target),
        .imem_ready    (imem_ready),
        .imem_req      (imem_req),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .choose        (choose),
        .redirect_pend (redirect_pend)
    );

    always #5 clk = ~clk;

    // Advance one clock and sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic compare(input logic [31:0] obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: observed %h required none", obs);
        end else begin
            e = exp_q.pop_front();
            vectors++;
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] val);
        expect_val(tag, val);
        compare(obs);
    endtask

    task automatic clear_req();
        br_taken = 1'b0;
        jump     = 1'b0;
        jr       = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; imem_ready = 1'b1;
        br_taken = 1'b0; jump = 1'b0; jr = 1'b0;
        br_target = 32'h0; jump_target = 32'h0; jr_target = 32'h0;

        // Reset two cycles.
        step();
        step();
        chk("reset_pc", pc, 32'h0000_3000);
        chk("reset_pend", {31'b0, redirect_pend}, 32'd0);
        chk("reset_choose", {30'b0, choose}, 32'd0);
        chk("reset_req", {31'b0, imem_req}, 32'd0);
        rst = 1'b0;
        step();
        chk("boot_pc", pc, 32'h0000_3000);
        chk("run_req", {31'b0, imem_req}, 32'd1);
        step();
        chk("seq_pc1", pc, 32'h0000_3004);
        step();
        chk("seq_pc2", pc, 32'h0000_3008);
        chk("pc_plus4", pc_plus4, 32'h0000_300C);

`ifdef DELAY_SLOT_EN
        // Jump accepted: slot fetch at pc+4 first, then target.
        jump = 1'b1; jump_target = 32'h0000_4000;
        #1;
        chk("slot_choose_seq", {30'b0, choose}, 32'd0);
        step();
        clear_req();
        chk("slot_pc", pc, 32'h0000_300C);
        chk("slot_pend", {31'b0, redirect_pend}, 32'd1);
        chk("slot_choose_j", {30'b0, choose}, 32'd2);
        // A second redirect during the slot is ignored.
        br_taken = 1'b1; br_target = 32'h0000_7700;
        step();
        clear_req();
        chk("slot_target", pc, 32'h0000_4000);
        chk("slot_pend_clr", {31'b0, redirect_pend}, 32'd0);
        step();
        chk("slot_after", pc, 32'h0000_4004);
`else
        // Branch with imem ready: 0-cycle select, 1-cycle PC.
        br_taken = 1'b1; br_target = 32'h0000_3100;
        #1;
        chk("br_choose", {30'b0, choose}, 32'd1);
        step();
        clear_req();
        chk("br_pc", pc, 32'h0000_3100);

        // Jump under back-pressure.
        imem_ready = 1'b0;
        jump = 1'b1; jump_target = 32'h0000_4000;
        #1;
        chk("j_choose_now", {30'b0, choose}, 32'd2);
        step();
        clear_req();
        chk("j_pend", {31'b0, redirect_pend}, 32'd1);
        chk("j_hold_choose", {30'b0, choose}, 32'd2);
        step();
        step();
        chk("j_pc_held", pc, 32'h0000_3100);
        chk("j_pend_held", {31'b0, redirect_pend}, 32'd1);
        imem_ready = 1'b1;
        step();
        chk("j_pc", pc, 32'h0000_4000);
        chk("j_pend_clr", {31'b0, redirect_pend}, 32'd0);

        // All three at once: jr wins.
        jr = 1'b1; jr_target = 32'h0000_5000;
        jump = 1'b1; jump_target = 32'h0000_6000;
        br_taken = 1'b1; br_target = 32'h0000_7000;
        #1;
        chk("prio_choose", {30'b0, choose}, 32'd3);
        step();
        clear_req();
        chk("prio_pc", pc, 32'h0000_5000);

        // Stall with one branch pulse.
        stall = 1'b1;
        br_taken = 1'b1; br_target = 32'h0000_5500;
        #1;
        chk("stall_req", {31'b0, imem_req}, 32'd0);
        step();
        clear_req();
        step();
        step();
        step();
        chk("stall_pc", pc, 32'h0000_5000);
        chk("stall_pend", {31'b0, redirect_pend}, 32'd1);
        stall = 1'b0;
        #1;
        chk("stall_choose", {30'b0, choose}, 32'd1);
        step();
        chk("stall_release_pc", pc, 32'h0000_5500);

        // Newest buffered redirect wins.
        imem_ready = 1'b0;
        br_taken = 1'b1; br_target = 32'h0000_9000;
        step();
        clear_req();
        jump = 1'b1; jump_target = 32'h0000_A000;
        step();
        clear_req();
        chk("newest_choose", {30'b0, choose}, 32'd2);
        imem_ready = 1'b1;
        step();
        chk("newest_pc", pc, 32'h0000_A000);

        // PC wrap.
        jr = 1'b1; jr_target = 32'hFFFF_FFFC;
        step();
        clear_req();
        chk("wrap_top", pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4, 32'h0000_0000);
        step();
        chk("wrap_pc", pc, 32'h0000_0000);

        // Reset during HOLD discards the buffered redirect.
        imem_ready = 1'b0;
        jump = 1'b1; jump_target = 32'h0000_8000;
        step();
        clear_req();
        chk("rst_hold_pend", {31'b0, redirect_pend}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        imem_ready = 1'b1;
        chk("rst_hold_pc", pc, 32'h0000_3000);
        chk("rst_hold_pend_clr", {31'b0, redirect_pend}, 32'd0);
        step();
        chk("rst_boot_pc", pc, 32'h0000_3000);
        step();
        chk("rst_seq_pc", pc, 32'h0000_3004);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
